stopwatch_display_scan: RTL and testbench
=========================================

// Module: stopwatch_display_scan
// PURPOSE
//  Read side of the stopwatch digit chain. The digit adders/registers write BCD
//  values; this block reads them and drives a multiplexed 4-digit 7-segment
//  display (mm:ss). It time-slices anodes, encodes each digit to segments, and
//  inserts a dead gap between slots against ghosting. Digits are snapshotted
//  once per frame so one frame never mixes old and new values.
// PARAMETERS
//  N_DIGITS       4      number of digit slots; digit index 0 = seconds units
//  REFRESH_DIV    50000  clk cycles per digit slot; must be > DEAD_CYCLES
//  DEAD_CYCLES    4      cycles at start of each slot with all anodes off; >= 1
//  ACTIVE_LOW     1      1: seg/dp/an asserted low; 0: asserted high
// PORTS
//  clk          in   1           system clock, rising edge
//  rst_n        in   1           async active-low reset
//  en           in   1           1 = scanning; 0 = display dark
//  digits       in   4*N_DIGITS  BCD digits, digit i at [4i+3:4i], bit 0 = LSB
//  blank_lz     in   1           1 = blank digit N_DIGITS-1 when it equals 0
//  colon        in   1           1 = light dp on digit 2 (mm:ss separator)
//  seg          out  7           segments {g,f,e,d,c,b,a}
//  dp           out  1           decimal point of the active digit
//  an           out  N_DIGITS    digit enables, one-hot when lit
//  frame_start  out  1           1-cycle pulse when digits are snapshotted
// BEHAVIOUR
//  - Reset (async assert, sync release): an/seg/dp all inactive, frame_start=0,
//    slot=0, cycle counter=0, state=DEAD, snapshot=0.
//  - Two states: DEAD (all anodes off, seg/dp inactive) for cycle counts
//    0..DEAD_CYCLES-1, then ON for DEAD_CYCLES..REFRESH_DIV-1. In ON, an[slot] is
//    asserted and seg/dp carry the slot's digit.
//  - At count REFRESH_DIV-1, count -> 0, slot -> slot+1. Slot N_DIGITS-1 wraps
//    to 0. Frame length = N_DIGITS*REFRESH_DIV cycles.
//  - Snapshot: on slot 0, count 0, all digits are latched into the snapshot and
//    frame_start pulses for that cycle. Changes on digits mid-frame never
//    appear before the next frame.
//  - Outputs are registered. The an/seg/dp pattern for a given count appears
//    one clk later.
//  - Encoding 0..9 uses the standard pattern (0 -> a..f, 1 -> b,c, 8 -> all).
//    Illegal codes 10..15 show dash: only g lit.
//  - Leading-zero blanking: if blank_lz=1 and snapshot digit N_DIGITS-1 = 0,
//    seg/dp stay inactive in that slot. The anode is still driven. Blanking
//    never applies to other digits.
//  - dp is lit only in slot 2 and only when colon=1. colon is sampled live, not
//    snapshotted.
//  - en=0: next cycle an/seg/dp go inactive. count, slot and state are held at
//    0/0/DEAD. When en returns to 1, scanning restarts at a frame start, with a
//    snapshot and a frame_start pulse.
//  - Reset mid-slot: outputs go inactive immediately (async). No partial slot
//    is resumed.
//  - ACTIVE_LOW applies as an output inversion only. Internal logic is
//    active-high.
// STRUCTURE
//  - stopwatch_pkg: scan_state_t {DEAD, ON}, 7-bit segment constants
//    SEG_0..SEG_9, SEG_DASH, SEG_OFF.
//  - Sub-module bcd_to_7seg (combinational 4b -> 7b using the package
//    constants). The scan FSM, counters, snapshot and output registers live
//    here.
// TESTING (REFRESH_DIV=8, DEAD_CYCLES=2, ACTIVE_LOW=0 unless stated)
//  1 Reset, then en=1, digits=16'h5_9_0_3: frame_start pulses once per 32 cycles.
//    Per slot: an=0 for 2 cycles, then an=0001 with seg=SEG_3 for 6 cycles, then
//    0010/SEG_0, 0100/SEG_9, 1000/SEG_5.
//  2 Change digits to 16'h1_2_3_4 during slot 1: the rest of the frame still
//    shows 5,9. The next frame shows 4,3,2,1.
//  3 digits=16'h0_0_4_7, blank_lz=1, colon=1: slot 3 has an=1000, seg=0.
//    Slot 2 has seg=SEG_0 and dp=1. dp=0 in all other slots.
//  4 digits=16'hC_0_0_A: slots 0 and 3 show seg=7'b1000000 (dash).
//  5 Drop en in slot 2: the next cycle all outputs are 0. Raise en 5 cycles
//    later: frame_start pulses and slot 0 DEAD restarts.
//  6 Assert rst_n=0 mid-ON: outputs go inactive without a clock edge.
//    ACTIVE_LOW=1 rerun of scenario 1 gives bitwise-inverted an/seg/dp.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared scan state type and 7-segment patterns for the stopwatch display
package stopwatch_pkg;

    typedef enum logic {
        DEAD = 1'b0,
        ON   = 1'b1
    } scan_state_t;

    // Segment order is {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD digit to active-high segment pattern
module bcd_to_7seg
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/stopwatch_display_scan.sv
// rtl/stopwatch_display_scan.sv - multiplexed mm:ss 7-segment scanner with per-frame digit snapshot
module stopwatch_display_scan
    import stopwatch_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 4,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic                  blank_lz,
    input  logic                  colon,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_start
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_ON     = CW'(DEAD_CYCLES);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(N_DIGITS - 1);
    localparam logic [SW-1:0] SLOT_COLON = SW'(2);

    scan_state_t           state, state_next;
    logic [CW-1:0]         count, count_next;
    logic [SW-1:0]         slot, slot_next;
    logic [3:0]            snap [N_DIGITS];
    logic                  snap_load;

    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  fs_q, fs_d;

    logic [3:0]            cur_digit;
    logic [6:0]            enc_seg;
    logic                  blank;

    assign cur_digit = snap[slot];

    bcd_to_7seg u_enc (
        .bcd (cur_digit),
        .seg (enc_seg)
    );

    // Only the most significant slot is ever a leading-zero candidate
    assign blank = blank_lz && (slot == SLOT_LAST) && (cur_digit == 4'd0);

    always_comb begin
        count_next = count;
        slot_next  = slot;
        snap_load  = 1'b0;
        fs_d       = 1'b0;
        an_d       = '0;
        seg_d      = SEG_OFF;
        dp_d       = 1'b0;

        if (!en) begin
            count_next = '0;
            slot_next  = '0;
        end else begin
            snap_load = (slot == '0) && (count == '0);
            fs_d      = snap_load;

            if (count == CNT_LAST) begin
                count_next = '0;
                slot_next  = (slot == SLOT_LAST) ? '0 : slot + 1'b1;
            end else begin
                count_next = count + 1'b1;
            end

            if (state == ON) begin
                an_d = N_DIGITS'(1) << slot;
                if (!blank) begin
                    seg_d = enc_seg;
                    dp_d  = colon && (slot == SLOT_COLON);
                end
            end
        end

        state_next = (count_next >= CNT_ON) ? ON : DEAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DEAD;
            count <= '0;
            slot  <= '0;
            an_q  <= '0;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b0;
            fs_q  <= 1'b0;
            for (int i = 0; i < N_DIGITS; i++) begin
                snap[i] <= 4'd0;
            end
        end else begin
            state <= state_next;
            count <= count_next;
            slot  <= slot_next;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            fs_q  <= fs_d;
            if (snap_load) begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    snap[i] <= digits[4*i +: 4];
                end
            end
        end
    end

    // Polarity is applied after the registers so reset forces the inactive level directly
    assign an          = an_q ^ {N_DIGITS{ACTIVE_LOW}};
    assign seg         = seg_q ^ {7{ACTIVE_LOW}};
    assign dp          = dp_q ^ ACTIVE_LOW;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// tb/tb_stopwatch_display_scan.sv - directed checks of the display scanner in both output polarities
module tb_stopwatch_display_scan;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] S6 = 7'b1111101;
    localparam logic [6:0] S7 = 7'b0000111;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1101111;
    localparam logic [6:0] SD = 7'b1000000;
    localparam logic [6:0] SX = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] digits;
    logic        blank_lz;
    logic        colon;

    logic [6:0]  seg_h, seg_l;
    logic        dp_h, dp_l;
    logic [3:0]  an_h, an_l;
    logic        fs_h, fs_l;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stopwatch_display_scan #(
        .N_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2), .ACTIVE_LOW(1'b0)
    ) u_hi (
        .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .blank_lz(blank_lz),
        .colon(colon), .seg(seg_h), .dp(dp_h), .an(an_h), .frame_start(fs_h)
    );

    stopwatch_display_scan #(
        .N_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2), .ACTIVE_LOW(1'b1)
    ) u_lo (
        .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .blank_lz(blank_lz),
        .colon(colon), .seg(seg_l), .dp(dp_l), .an(an_l), .frame_start(fs_l)
    );

    typedef struct {
        string       name;
        logic [15:0] digits;
        logic        blank;
        logic        colon;
        logic [27:0] segs;
        logic [3:0]  dps;
    } vec_t;

    vec_t vecs [5];

    // k counts sampled cycles since the frame's snapshot edge; expected = {fs, an, seg, dp}
    task automatic check(input int k, input logic on, input logic [27:0] segs,
                         input logic [3:0] dps, input string tag);
        int pos;
        int s;
        int c;
        logic [12:0] e;
        logic [12:0] el;
        logic [12:0] ah;
        logic [12:0] al;
        pos = k % 32;
        s   = pos / 8;
        c   = pos % 8;
        e   = '0;
        if (on) begin
            e[12] = (pos == 0);
            if (c >= 2) begin
                e[11:8] = 4'(1 << s);
                e[7:1]  = segs[7*s +: 7];
                e[0]    = dps[s];
            end
        end
        el = {e[12], ~e[11:0]};
        ah = {fs_h, an_h, seg_h, dp_h};
        al = {fs_l, an_l, seg_l, dp_l};
        total++;
        if (ah !== e) begin
            bad++;
            $display("FAIL %s k=%0d high-polarity got=%h want=%h", tag, k, ah, e);
        end
        total++;
        if (al !== el) begin
            bad++;
            $display("FAIL %s k=%0d low-polarity got=%h want=%h", tag, k, al, el);
        end
    endtask

    task automatic run_frame(input logic [27:0] segs, input logic [3:0] dps, input string tag);
        for (int k = 0; k < 32; k++) begin
            @(posedge clk);
            #1;
            check(k, 1'b1, segs, dps, tag);
        end
    endtask

    task automatic restart(input logic [15:0] d, input logic b, input logic c);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        digits   = d;
        blank_lz = b;
        colon    = c;
        en       = 1'b1;
    endtask

    initial begin
        vecs[0] = '{"basic_5903",  16'h5903, 1'b0, 1'b0, {S5, S9, S0, S3}, 4'b0000};
        vecs[1] = '{"blank_colon", 16'h0047, 1'b1, 1'b1, {SX, S0, S4, S7}, 4'b0100};
        vecs[2] = '{"illegal",     16'hC00A, 1'b0, 1'b0, {SD, S0, S0, SD}, 4'b0000};
        vecs[3] = '{"no_blank",    16'h0047, 1'b0, 1'b1, {S0, S0, S4, S7}, 4'b0100};
        vecs[4] = '{"nonzero_msd", 16'h8621, 1'b1, 1'b0, {S8, S6, S2, S1}, 4'b0000};

        rst_n    = 1'b0;
        en       = 1'b0;
        digits   = 16'h0;
        blank_lz = 1'b0;
        colon    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check(1, 1'b0, 28'h0, 4'h0, "reset");
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            restart(vecs[v].digits, vecs[v].blank, vecs[v].colon);
            run_frame(vecs[v].segs, vecs[v].dps, vecs[v].name);
        end

        // Mid-frame digit change must wait for the next snapshot
        restart(16'h5903, 1'b0, 1'b0);
        for (int k = 0; k < 64; k++) begin
            @(posedge clk);
            #1;
            if (k < 32) check(k, 1'b1, {S5, S9, S0, S3}, 4'b0000, "midframe_old");
            else        check(k, 1'b1, {S1, S2, S3, S4}, 4'b0000, "midframe_new");
            if (k == 9) digits = 16'h1234;
        end

        // Drop en in slot 2, hold five cycles, then restart from a frame boundary
        restart(16'h5903, 1'b0, 1'b1);
        for (int k = 0; k < 19; k++) begin
            @(posedge clk);
            #1;
            check(k, 1'b1, {S5, S9, S0, S3}, 4'b0100, "pre_disable");
        end
        @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check(k + 1, 1'b0, 28'h0, 4'h0, "disabled");
        end
        @(negedge clk);
        en = 1'b1;
        run_frame({S5, S9, S0, S3}, 4'b0100, "reenable");

        // Async reset mid-ON slot, then a clean frame with no partial resume
        restart(16'h5903, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check(k, 1'b1, {S5, S9, S0, S3}, 4'b0000, "pre_reset");
        end
        #2;
        rst_n = 1'b0;
        #1;
        check(1, 1'b0, 28'h0, 4'h0, "async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame({S5, S9, S0, S3}, 4'b0000, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
